// File: rtl/br_tx_queue_pkg.sv
// Shared DMNI definitions for the BrLite transmit queue: the BrLite output
// payload, the cfg MMR register map and the STATUS word bit offsets.
package br_tx_queue_pkg;

    // Payload presented to the BrLite router local port (MSB first).
    typedef struct packed {
        logic [1:0]  service;
        logic [7:0]  ksvc;
        logic [15:0] target;
        logic [15:0] producer;
        logic [31:0] payload;
    } brlite_out_t;

    // cfg MMR register select.
    typedef enum logic [3:0] {
        TXQ_SERVICE  = 4'd0,
        TXQ_KSVC     = 4'd1,
        TXQ_TARGET   = 4'd2,
        TXQ_PRODUCER = 4'd3,
        TXQ_PAYLOAD  = 4'd4,
        TXQ_PUSH     = 4'd5,
        TXQ_FLUSH    = 4'd6,
        TXQ_IRQ_EN   = 4'd7,
        TXQ_IRQ_ACK  = 4'd8,
        TXQ_STATUS   = 4'd9
    } br_txq_mmr_t;

    // STATUS flag positions, relative to the top of the occupancy count field.
    // The absolute bit index is CNT_W + <offset>.
    localparam int STAT_BUSY_OFS     = 0;
    localparam int STAT_REQ_OFS      = 1;
    localparam int STAT_EMPTY_OFS    = 2;
    localparam int STAT_FULL_OFS     = 3;
    localparam int STAT_DRAINED_OFS  = 4;
    localparam int STAT_OVERFLOW_OFS = 5;

endpackage

// File: rtl/br_txq_fifo.sv
// Generic circular buffer used as the BrLite transmit queue. Supports a
// flush that optionally keeps the current head entry (the one in flight).
module br_txq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic             flush_keep_head_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;
    logic             push_ok;
    logic             keep_head;

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue is only accepted when the head leaves in the
    // same cycle; a flush always discards a coincident push. A head that pops
    // in the flush cycle is not kept.
    always_comb begin
        pop_ok     = pop_i && !empty_o;
        push_ok    = push_i && !flush_i && (!full_o || pop_ok);
        keep_head  = flush_keep_head_i && !pop_ok && !empty_o;
        rd_ptr_nxt = rd_ptr_q + PTR_W'(pop_ok);
    end

    // Entry storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= rd_ptr_nxt;
            wr_ptr_q <= rd_ptr_nxt + PTR_W'(keep_head);
            count_q  <= CNT_W'(keep_head);
        end else begin
            rd_ptr_q <= rd_ptr_nxt;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/br_tx_queue.sv
// BrLite send path with a DEPTH-entry transmit queue. The CPU stages an entry
// through the cfg MMR bus and pushes it; the queue head is offered to the
// router local port with a registered req and a one-cycle ack pulse.
module br_tx_queue
    import br_tx_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_en_i,
    input  logic        cfg_we_i,
    input  br_txq_mmr_t cfg_addr_i,
    input  logic [31:0] cfg_data_i,
    output logic [31:0] cfg_data_o,
    output logic        irq_o,
    input  logic        br_local_busy_i,
    output logic        br_req_o,
    input  logic        br_ack_i,
    output brlite_out_t br_data_o
);

    localparam int ENTRY_W = $bits(brlite_out_t);

    brlite_out_t        staging_q;
    logic [1:0]         irq_en_q;
    logic               drained_q;
    logic               overflow_q;
    logic               req_q;

    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    logic               cfg_wr;
    logic               push_wr;
    logic               flush_wr;
    logic               irq_ack_wr;
    logic               pop;
    logic               push_acc;
    logic               drained_set;
    logic               overflow_set;
    logic [31:0]        status;

    // Decode MMR writes and the handshake events that drive the flags. The
    // queue counts as drained when an ack leaves it empty, including an ack
    // that coincides with a flush.
    always_comb begin
        cfg_wr       = cfg_en_i && cfg_we_i;
        push_wr      = cfg_wr && (cfg_addr_i == TXQ_PUSH);
        flush_wr     = cfg_wr && (cfg_addr_i == TXQ_FLUSH) && cfg_data_i[0];
        irq_ack_wr   = cfg_wr && (cfg_addr_i == TXQ_IRQ_ACK);
        pop          = req_q && br_ack_i;
        push_acc     = push_wr && !flush_wr && (!fifo_full || pop);
        drained_set  = pop && !push_acc && ((fifo_count == CNT_W'(1)) || flush_wr);
        overflow_set = push_wr && !flush_wr && fifo_full && !pop;
    end

    br_txq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .push_i            (push_wr),
        .pop_i             (pop),
        .flush_i           (flush_wr),
        .flush_keep_head_i (req_q),
        .data_i            (staging_q),
        .head_o            (fifo_head),
        .count_o           (fifo_count),
        .full_o            (fifo_full),
        .empty_o           (fifo_empty)
    );

    assign br_data_o = brlite_out_t'(fifo_head);
    assign br_req_o  = req_q;
    assign irq_o     = (irq_en_q[0] && drained_q) || (irq_en_q[1] && overflow_q);

    // Staging registers and interrupt enables; staging persists across pushes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            staging_q <= '0;
            irq_en_q  <= '0;
        end else if (cfg_wr) begin
            case (cfg_addr_i)
                TXQ_SERVICE:  staging_q.service  <= cfg_data_i[1:0];
                TXQ_KSVC:     staging_q.ksvc     <= cfg_data_i[7:0];
                TXQ_TARGET:   staging_q.target   <= cfg_data_i[15:0];
                TXQ_PRODUCER: staging_q.producer <= cfg_data_i[15:0];
                TXQ_PAYLOAD:  staging_q.payload  <= cfg_data_i;
                TXQ_IRQ_EN:   irq_en_q           <= cfg_data_i[1:0];
                default:      ;
            endcase
        end
    end

    // Sticky drained/overflow flags; a set event beats a coincident clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drained_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            drained_q  <= drained_set  || (drained_q  && !(irq_ack_wr && cfg_data_i[0]));
            overflow_q <= overflow_set || (overflow_q && !(irq_ack_wr && cfg_data_i[1]));
        end
    end

    // Request holds until acked regardless of busy; it drops for at least one
    // cycle after each ack and never rises into a queue that is being flushed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= 1'b0;
        end else if (req_q) begin
            if (br_ack_i) begin
                req_q <= 1'b0;
            end
        end else if (!fifo_empty && !br_local_busy_i && !br_ack_i && !flush_wr) begin
            req_q <= 1'b1;
        end
    end

    // Combinational read port; only STATUS returns non-zero data.
    always_comb begin
        status                                  = '0;
        status[CNT_W-1:0]                       = fifo_count;
        status[CNT_W + STAT_BUSY_OFS]           = br_local_busy_i;
        status[CNT_W + STAT_REQ_OFS]            = req_q;
        status[CNT_W + STAT_EMPTY_OFS]          = fifo_empty;
        status[CNT_W + STAT_FULL_OFS]           = fifo_full;
        status[CNT_W + STAT_DRAINED_OFS]        = drained_q;
        status[CNT_W + STAT_OVERFLOW_OFS]       = overflow_q;
        cfg_data_o = (cfg_en_i && !cfg_we_i && (cfg_addr_i == TXQ_STATUS)) ? status : 32'h0;
    end

endmodule

// File: tb/tb_br_tx_queue.sv
// Scoreboard bench for br_tx_queue (DEPTH=4, so STATUS bits are:
// count[2:0], busy 3, req 4, empty 5, full 6, drained 7, overflow 8).
module tb_br_tx_queue;
    import br_tx_queue_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cfg_en_i;
    logic        cfg_we_i;
    br_txq_mmr_t cfg_addr_i;
    logic [31:0] cfg_data_i;
    logic [31:0] cfg_data_o;
    logic        irq_o;
    logic        br_local_busy_i;
    logic        br_req_o;
    logic        br_ack_i;
    brlite_out_t br_data_o;

    int total = 0;
    int bad   = 0;
    brlite_out_t sb[$];

    br_tx_queue #(.DEPTH(4)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cfg_en_i        (cfg_en_i),
        .cfg_we_i        (cfg_we_i),
        .cfg_addr_i      (cfg_addr_i),
        .cfg_data_i      (cfg_data_i),
        .cfg_data_o      (cfg_data_o),
        .irq_o           (irq_o),
        .br_local_busy_i (br_local_busy_i),
        .br_req_o        (br_req_o),
        .br_ack_i        (br_ack_i),
        .br_data_o       (br_data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic brlite_out_t mkExp(logic [31:0] p);
        brlite_out_t e;
        e.service  = 2'd2;
        e.ksvc     = 8'h11;
        e.target   = 16'h0203;
        e.producer = 16'h0405;
        e.payload  = p;
        return e;
    endfunction

    task automatic checkOutput(string name, logic [79:0] act, logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cfg write, driven from a negedge, captured on the next posedge.
    task automatic applyStimulus(br_txq_mmr_t addr, logic [31:0] data);
        @(negedge clk_i);
        cfg_en_i   = 1'b1;
        cfg_we_i   = 1'b1;
        cfg_addr_i = addr;
        cfg_data_i = data;
        @(posedge clk_i);
        #1;
        cfg_en_i = 1'b0;
        cfg_we_i = 1'b0;
    endtask

    // cfg write issued in the same cycle as an ack pulse.
    task automatic applyWithAck(br_txq_mmr_t addr, logic [31:0] data);
        @(negedge clk_i);
        br_ack_i   = 1'b1;
        cfg_en_i   = 1'b1;
        cfg_we_i   = 1'b1;
        cfg_addr_i = addr;
        cfg_data_i = data;
        @(posedge clk_i);
        #1;
        br_ack_i = 1'b0;
        cfg_en_i = 1'b0;
        cfg_we_i = 1'b0;
    endtask

    task automatic pushEntry(logic [31:0] p, bit expect_accept);
        applyStimulus(TXQ_PAYLOAD, p);
        applyStimulus(TXQ_PUSH, 32'h0);
        if (expect_accept) sb.push_back(mkExp(p));
    endtask

    task automatic checkStatus(string name, logic [31:0] exp);
        logic [31:0] v;
        cfg_en_i   = 1'b1;
        cfg_we_i   = 1'b0;
        cfg_addr_i = TXQ_STATUS;
        #1;
        v        = cfg_data_o;
        cfg_en_i = 1'b0;
        checkOutput(name, 80'(v), 80'(exp));
    endtask

    // Bounded wait for req; returns on a negedge.
    task automatic waitReq();
        int n = 0;
        @(negedge clk_i);
        while (!br_req_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("req_wait", 80'(br_req_o), 80'(1));
    endtask

    task automatic doAck();
        waitReq();
        if (br_req_o) begin
            br_ack_i = 1'b1;
            @(posedge clk_i);
            #1;
            br_ack_i = 1'b0;
        end
    endtask

    // Monitor: every accepted handshake is checked against the scoreboard.
    always @(negedge clk_i) begin
        #2;
        if (rst_ni && br_req_o && br_ack_i) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_send: got %0h expected none", br_data_o);
            end else begin
                checkOutput("send_data", 80'(br_data_o), 80'(sb.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_ni          = 1'b0;
        cfg_en_i        = 1'b0;
        cfg_we_i        = 1'b0;
        cfg_addr_i      = TXQ_SERVICE;
        cfg_data_i      = '0;
        br_local_busy_i = 1'b0;
        br_ack_i        = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        $display("[TB] reset checks");
        checkOutput("rst_req", 80'(br_req_o), 80'(0));
        checkOutput("rst_irq", 80'(irq_o), 80'(0));
        checkOutput("rst_data", 80'(br_data_o), 80'(0));
        checkStatus("rst_status", 32'h20);
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("[TB] single entry");
        applyStimulus(TXQ_SERVICE, 32'hFFFF_FFFE);
        applyStimulus(TXQ_KSVC, 32'h0000_0011);
        applyStimulus(TXQ_TARGET, 32'hABCD_0203);
        applyStimulus(TXQ_PRODUCER, 32'h0000_0405);
        applyStimulus(TXQ_PAYLOAD, 32'hDEAD_BEEF);
        applyStimulus(TXQ_PUSH, 32'h0);
        sb.push_back(mkExp(32'hDEAD_BEEF));
        checkOutput("lat_req_p1", 80'(br_req_o), 80'(0));
        @(posedge clk_i);
        #1;
        checkOutput("lat_req_p2", 80'(br_req_o), 80'(1));
        checkOutput("head_data", 80'(br_data_o), 80'(mkExp(32'hDEAD_BEEF)));
        checkStatus("one_status", 32'h11);
        doAck();
        checkOutput("ack_req", 80'(br_req_o), 80'(0));
        checkStatus("drained_status", 32'hA0);
        checkOutput("irq_masked", 80'(irq_o), 80'(0));
        applyStimulus(TXQ_IRQ_EN, 32'h1);
        checkOutput("irq_drained", 80'(irq_o), 80'(1));
        applyStimulus(TXQ_IRQ_ACK, 32'h1);
        checkOutput("irq_cleared", 80'(irq_o), 80'(0));

        $display("[TB] fill and overflow");
        for (int i = 1; i <= 4; i++) pushEntry(32'(i), 1'b1);
        pushEntry(32'd5, 1'b0);
        checkStatus("full_status", 32'h154);
        checkOutput("irq_ovf_masked", 80'(irq_o), 80'(0));
        applyStimulus(TXQ_IRQ_EN, 32'h2);
        checkOutput("irq_ovf", 80'(irq_o), 80'(1));
        applyStimulus(TXQ_IRQ_ACK, 32'h2);
        checkOutput("irq_ovf_clr", 80'(irq_o), 80'(0));
        repeat (4) doAck();
        checkStatus("fill_drained", 32'hA0);
        applyStimulus(TXQ_IRQ_ACK, 32'h3);

        $display("[TB] local busy");
        @(negedge clk_i);
        br_local_busy_i = 1'b1;
        pushEntry(32'h10, 1'b1);
        pushEntry(32'h11, 1'b1);
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("busy_req", 80'(br_req_o), 80'(0));
        checkStatus("busy_status", 32'h0A);
        @(negedge clk_i);
        br_local_busy_i = 1'b0;
        #1;
        checkOutput("unbusy_pre", 80'(br_req_o), 80'(0));
        @(posedge clk_i);
        #1;
        checkOutput("unbusy_req", 80'(br_req_o), 80'(1));
        @(negedge clk_i);
        br_local_busy_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("busy_hold", 80'(br_req_o), 80'(1));
        doAck();
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("busy_after_ack", 80'(br_req_o), 80'(0));
        @(negedge clk_i);
        br_local_busy_i = 1'b0;
        doAck();
        applyStimulus(TXQ_IRQ_ACK, 32'h3);

        $display("[TB] push while full with ack");
        for (int i = 0; i < 4; i++) pushEntry(32'h21 + 32'(i), 1'b1);
        applyStimulus(TXQ_PAYLOAD, 32'h25);
        waitReq();
        applyWithAck(TXQ_PUSH, 32'h0);
        sb.push_back(mkExp(32'h25));
        checkStatus("full_ack_status", 32'h44);
        repeat (4) doAck();
        applyStimulus(TXQ_IRQ_ACK, 32'h3);

        $display("[TB] flush");
        pushEntry(32'h31, 1'b1);
        pushEntry(32'h32, 1'b0);
        pushEntry(32'h33, 1'b0);
        waitReq();
        applyStimulus(TXQ_FLUSH, 32'h1);
        checkStatus("flush_keep", 32'h11);
        doAck();
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("flush_no_rereq", 80'(br_req_o), 80'(0));
        checkStatus("flush_drained", 32'hA0);
        applyStimulus(TXQ_IRQ_ACK, 32'h1);
        @(negedge clk_i);
        br_local_busy_i = 1'b1;
        pushEntry(32'h41, 1'b0);
        pushEntry(32'h42, 1'b0);
        checkStatus("preflush", 32'h0A);
        applyStimulus(TXQ_FLUSH, 32'h1);
        checkStatus("flush_empty", 32'h28);
        @(negedge clk_i);
        br_local_busy_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("flush_empty_req", 80'(br_req_o), 80'(0));

        $display("[TB] irq ack vs drain");
        applyStimulus(TXQ_IRQ_EN, 32'h1);
        pushEntry(32'h51, 1'b1);
        waitReq();
        applyWithAck(TXQ_IRQ_ACK, 32'h1);
        checkStatus("set_wins", 32'hA0);
        checkOutput("set_wins_irq", 80'(irq_o), 80'(1));

        $display("[TB] reset mid-transfer");
        pushEntry(32'h61, 1'b0);
        waitReq();
        rst_ni = 1'b0;
        #1;
        checkOutput("mid_rst_req", 80'(br_req_o), 80'(0));
        checkOutput("mid_rst_irq", 80'(irq_o), 80'(0));
        checkOutput("mid_rst_data", 80'(br_data_o), 80'(0));
        checkStatus("mid_rst_status", 32'h20);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("sb_empty", 80'(sb.size()), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/br_tx_queue.md
Name: br_tx_queue

Overview:
- Parametrised successor to the NI BrLite send path: replaces the single-shot BrLite output register with a DEPTH-entry transmit queue.
- The CPU fills staging registers over the cfg MMR bus, then pushes; the queue head drives the BrLite output port with a req/ack handshake.
- Adds occupancy status, sticky overflow, flush, and a maskable "queue drained" interrupt.
- Sits between the CPU cfg bus and the BrLite router local port inside the DMNI.

Parameters:
- DEPTH, 4, number of queued broadcast entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_en_i  in  1  MMR access strobe
- cfg_we_i  in  1  write enable
- cfg_addr_i  in  br_txq_mmr_t  register select
- cfg_data_i  in  32  write data
- cfg_data_o  out  32  read data (combinational)
- irq_o  out  1  interrupt request
- br_local_busy_i  in  1  router local port busy
- br_req_o  out  1  broadcast request
- br_ack_i  in  1  one-cycle accept pulse from router
- br_data_o  out  brlite_out_t  head entry payload

Behaviour:
- Reset: all outputs 0; queue empty; count 0; staging 0; irq_en 0; drained and overflow flags 0.
- Staging writes take effect next cycle:
  - TXQ_SERVICE ← data[1:0]
  - TXQ_KSVC ← data[7:0]
  - TXQ_TARGET ← data[15:0]
  - TXQ_PRODUCER ← data[15:0]
  - TXQ_PAYLOAD ← data[31:0]
- Staging contents persist after a push, so repeated pushes resend the same entry.
- TXQ_PUSH write (any data): enqueue staging at the tail.
  - Full with no pop in the same cycle: push dropped, overflow set (sticky).
  - Full with a pop in the same cycle: push accepted, count unchanged.
- Send handshake:
  - br_req_o is registered.
  - Set when the queue is non-empty, br_local_busy_i=0, and no ack this cycle.
  - Once high, br_req_o holds until br_ack_i, regardless of busy.
  - On br_ack_i: pop the head and clear br_req_o for one cycle. The next entry raises req no earlier than 2 cycles after the previous ack.
  - br_data_o always equals the head entry; it is stable while br_req_o=1.
  - br_ack_i while br_req_o=0 is ignored; no pop.
- Push-to-req latency on an idle, empty queue: 2 cycles (write cycle → entry visible → req registered).
- TXQ_FLUSH write (data[0]=1):
  - br_req_o=0: empty the queue; count becomes 0.
  - br_req_o=1: keep the in-flight head and discard the rest; count becomes 1. The head completes normally.
  - Flush in the same cycle as a push: flush wins and the push is discarded. Overflow is unaffected.
- Drained flag: set when an ack pops the last entry (count 1→0 without a simultaneous push).
- TXQ_IRQ_EN ← data[1:0]: bit0 enables drained, bit1 enables overflow.
- irq_o = (en[0]&drained) | (en[1]&overflow); combinational from registers.
- TXQ_IRQ_ACK write: data[0] clears drained, data[1] clears overflow. If a clear coincides with a set event, the set wins.
- TXQ_STATUS read: {overflow, drained, full, empty, br_req_o, local_busy, count}, zero-extended; count occupies [CNT_W-1:0], flags occupy the bits above it.
- Other addresses read 0; writes to them are ignored.
- Pointers: DEPTH-modulo wrap. Count saturates by construction; never exceeds DEPTH.
- Reset mid-transfer: everything returns to reset values immediately; the outstanding request is abandoned.

Decomposition:
- Shared DMNI package gets:
  - br_txq_mmr_t enum: TXQ_SERVICE, TXQ_KSVC, TXQ_TARGET, TXQ_PRODUCER, TXQ_PAYLOAD, TXQ_PUSH, TXQ_FLUSH, TXQ_IRQ_EN, TXQ_IRQ_ACK, TXQ_STATUS.
  - Status bit-position constants.
- brlite_out_t is reused from the package.
- One sub-module: br_txq_fifo (generic DEPTH×$bits(brlite_out_t) circular buffer with push/pop/flush_keep_head, count/full/empty).

Test Plan:
- Reset, stage service=2, ksvc=0x11, target=0x0203, producer=0x0405, payload=0xDEADBEEF, push → br_req_o=1 at cycle +2 with exactly those fields; ack → req=0, count=0, drained=1; irq_o=1 only after IRQ_EN=1.
- Push 4 entries (payloads 1..4) with DEPTH=4, then a 5th push → full=1, overflow=1, 5th dropped; four acks deliver payloads 1,2,3,4 in order.
- Hold br_local_busy_i=1 with 2 queued → req stays 0; release busy → req rises next cycle; busy re-asserted while req=1 → req holds until ack.
- Push while full in the same cycle as an ack → count stays 4, overflow stays 0, new entry delivered last.
- 3 queued, req=1, flush → count=1; head ack completes and req does not reassert; flush with req=0 → count=0.
- IRQ_ACK clearing drained in the same cycle that the last pop sets drained → drained remains 1.
